// File: rtl/avalon_burst_agent.sv
// Avalon-MM burst slave backed by an internal word memory.
// Reads return data two cycles after acceptance; write bursts may stall on write=0.
//
// state    | meaning
// IDLE     | ready for a new command, single-beat writes complete here
// RD_LAT   | read accepted, first beat being fetched
// RD_DATA  | streaming read beats (with optional bubbles)
// WR_BURST | collecting the remaining beats of a write burst
module avalon_burst_agent #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WIDTH   = 10,
  parameter int MAX_BURST     = 16,
  parameter int BUBBLE_PERIOD = 0,
  parameter int INIT_PATTERN  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   address,
  input  logic                          read,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         writedata,
  input  logic [DATA_WIDTH/8-1:0]       byteenable,
  input  logic [$clog2(MAX_BURST):0]    burstcount,
  output logic                          waitrequest,
  output logic [DATA_WIDTH-1:0]         readdata,
  output logic                          readdatavalid
);

  localparam int BC_W   = $clog2(MAX_BURST) + 1;
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BUB_W  = $clog2(BUBBLE_PERIOD + 1) + 1;

  typedef enum logic [1:0] {IDLE, RD_LAT, RD_DATA, WR_BURST} state_t;

  state_t state, state_nxt;

  // Words never written read back as their own index; this keeps the
  // power-up pattern without a reset that would disturb memory contents.
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]       written = '0;

  logic [DEPTH_WIDTH-1:0] cmd_idx;
  logic [BC_W-1:0]        cmd_beats;
  logic [DEPTH_WIDTH-1:0] rd_idx;
  logic [DEPTH_WIDTH-1:0] wr_idx;
  logic [BC_W-1:0]        beats_left;
  logic [BUB_W-1:0]       bubble_cnt;
  logic                   rd_done;
  logic                   bubble_due;
  logic [DATA_WIDTH-1:0]  rd_word;

  logic                   mem_we;
  logic [DEPTH_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]  old_word;
  logic [DATA_WIDTH-1:0]  merged;

  logic                   unused_addr_bits;

  assign cmd_idx          = address[DEPTH_WIDTH+1:2];
  assign unused_addr_bits = ^{address[31:DEPTH_WIDTH+2], address[1:0]};

  always_comb begin
    if (burstcount == '0) begin
      cmd_beats = BC_W'(1);
    end else if (burstcount > BC_W'(MAX_BURST)) begin
      cmd_beats = BC_W'(MAX_BURST);
    end else begin
      cmd_beats = burstcount;
    end
  end

  assign rd_done    = (beats_left == '0);
  assign bubble_due = (BUBBLE_PERIOD != 0) && (bubble_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    waitrequest = reset || (state == RD_LAT) || (state == RD_DATA);
    case (state)
      IDLE: begin
        if (read) begin
          state_nxt = RD_LAT;
        end else if (write && (cmd_beats > BC_W'(1))) begin
          state_nxt = WR_BURST;
        end
      end
      RD_LAT:   state_nxt = RD_DATA;
      RD_DATA:  if (rd_done) state_nxt = IDLE;
      WR_BURST: if (write && (beats_left == BC_W'(1))) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Write port: a read presented alongside a write in IDLE wins.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cmd_idx;
    if (!reset) begin
      case (state)
        IDLE:     mem_we = write && !read;
        WR_BURST: begin
          mem_we    = write;
          mem_waddr = wr_idx;
        end
        default:  mem_we = 1'b0;
      endcase
    end
  end

  always_comb begin
    if ((INIT_PATTERN != 0) && !written[mem_waddr]) begin
      old_word = DATA_WIDTH'(mem_waddr);
    end else begin
      old_word = mem[mem_waddr];
    end
    for (int b = 0; b < NBYTES; b++) begin
      merged[8*b +: 8] = byteenable[b] ? writedata[8*b +: 8] : old_word[8*b +: 8];
    end
  end

  always_comb begin
    if ((INIT_PATTERN != 0) && !written[rd_idx]) begin
      rd_word = DATA_WIDTH'(rd_idx);
    end else begin
      rd_word = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr]     <= merged;
      written[mem_waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
      beats_left    <= '0;
      bubble_cnt    <= '0;
      rd_idx        <= '0;
      wr_idx        <= '0;
    end else begin
      readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (read) begin
            rd_idx     <= cmd_idx;
            beats_left <= cmd_beats;
            bubble_cnt <= BUB_W'(BUBBLE_PERIOD);
          end else if (write) begin
            wr_idx     <= cmd_idx + 1'b1;
            beats_left <= cmd_beats - 1'b1;
          end
        end
        RD_DATA: begin
          if (!rd_done) begin
            if (bubble_due) begin
              bubble_cnt <= BUB_W'(BUBBLE_PERIOD);
            end else begin
              readdata      <= rd_word;
              readdatavalid <= 1'b1;
              rd_idx        <= rd_idx + 1'b1;
              beats_left    <= beats_left - 1'b1;
              if (BUBBLE_PERIOD != 0) bubble_cnt <= bubble_cnt - 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (write) begin
            wr_idx     <= wr_idx + 1'b1;
            beats_left <= beats_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_burst_agent.sv
// Directed bench: two agents (no bubbles / BUBBLE_PERIOD=4) share the same stimulus.
module tb_avalon_burst_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [4:0]  burstcount;
  logic        wr0, wr4, rdv0, rdv4;
  logic [31:0] rd0, rd4;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [1024];
  logic [31:0] wbuf  [16];
  logic [31:0] first_data;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  bc;
    int          exp_n;
    logic [31:0] exp_first;
  } rd_vec_t;

  rd_vec_t vecs [5];

  always #5 clk = ~clk;

  avalon_burst_agent #(.DATA_WIDTH(32), .DEPTH_WIDTH(10), .MAX_BURST(16),
                       .BUBBLE_PERIOD(0), .INIT_PATTERN(1)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .waitrequest(wr0), .readdata(rd0), .readdatavalid(rdv0)
  );

  avalon_burst_agent #(.DATA_WIDTH(32), .DEPTH_WIDTH(10), .MAX_BURST(16),
                       .BUBBLE_PERIOD(4), .INIT_PATTERN(1)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .waitrequest(wr4), .readdata(rd4), .readdatavalid(rdv4)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge. Samples 40 cycles on both agents.
  task automatic read_check(input string nm, input logic [31:0] addr, input logic [4:0] bc,
                            input int exp_n, input bit with_write);
    int          base;
    int          nb [2];
    int          first [2];
    int          last [2];
    int          wlow [2];
    int          derr [2];
    int          exp_last [2];
    logic [31:0] prev [2];
    logic [31:0] rdat [2];
    logic        v [2];
    logic        w [2];
    base       = int'(addr[11:2]);
    address    = addr;
    burstcount = bc;
    read       = 1'b1;
    write      = with_write;
    #1;
    check({nm, "_ready0"}, longint'(wr0), 0);
    check({nm, "_ready4"}, longint'(wr4), 0);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nb[d] = 0; first[d] = -1; last[d] = -1; wlow[d] = -1; derr[d] = 0; prev[d] = '0;
    end
    for (int s = 0; s < 40; s++) begin
      v[0] = rdv0; v[1] = rdv4;
      rdat[0] = rd0; rdat[1] = rd4;
      w[0] = wr0; w[1] = wr4;
      for (int d = 0; d < 2; d++) begin
        if (v[d]) begin
          if (nb[d] == 0 && d == 0) first_data = rdat[d];
          if (rdat[d] !== model[(base + nb[d]) % 1024]) derr[d]++;
          if (first[d] < 0) first[d] = s;
          last[d] = s;
          nb[d]++;
        end else if (s > 0 && rdat[d] !== prev[d]) begin
          derr[d]++;
        end
        if (!w[d] && wlow[d] < 0) wlow[d] = s;
        prev[d] = rdat[d];
      end
      @(negedge clk);
    end
    exp_last[0] = 1 + exp_n;
    exp_last[1] = 1 + exp_n + (exp_n - 1) / 4;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_beats", nm, d), nb[d], exp_n);
      check($sformatf("%s_d%0d_first", nm, d), first[d], 2);
      check($sformatf("%s_d%0d_last", nm, d), last[d], exp_last[d]);
      check($sformatf("%s_d%0d_wrlow", nm, d), wlow[d], exp_last[d] + 1);
      check($sformatf("%s_d%0d_dataerr", nm, d), derr[d], 0);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the last beat's edge.
  task automatic write_burst(input logic [31:0] addr, input int n, input logic [3:0] be,
                             input int gap_at, input int gap_len, output int rdv_seen);
    int          widx;
    logic [31:0] mask;
    widx     = int'(addr[11:2]);
    rdv_seen = 0;
    mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          write   = 1'b0;
          read    = 1'b1;
          address = 32'hDEAD_BEEC;
          @(negedge clk);
          if (rdv0 || rdv4) rdv_seen++;
        end
      end
      write      = 1'b1;
      read       = 1'b0;
      writedata  = wbuf[b];
      byteenable = be;
      address    = (b == 0) ? addr : 32'hFFFF_FFFC;
      burstcount = (b == 0) ? 5'(n) : 5'd1;
      model[(widx + b) % 1024] = (model[(widx + b) % 1024] & ~mask) | (wbuf[b] & mask);
      @(negedge clk);
      if (rdv0 || rdv4) rdv_seen++;
    end
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    int nb;
    int extra;
    reset      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    burstcount = '0;
    for (int i = 0; i < 1024; i++) model[i] = 32'(i);

    vecs[0] = '{32'h0000_0040, 5'd16, 16, 32'h10};
    vecs[1] = '{32'h0000_0FF8, 5'd4,  4,  32'h3FE};
    vecs[2] = '{32'h0000_0000, 5'd0,  1,  32'h0};
    vecs[3] = '{32'h0000_0013, 5'd31, 16, 32'h4};
    vecs[4] = '{32'h1234_5678, 5'd3,  3,  32'h19E};

    repeat (2) @(negedge clk);
    check("rst_rdv0", longint'(rdv0), 0);
    check("rst_rdv4", longint'(rdv4), 0);
    check("rst_rd0", longint'(rd0), 0);
    check("rst_wr0", longint'(wr0), 1);
    check("rst_wr4", longint'(wr4), 1);
    reset = 1'b0;
    #1;
    check("rel_wr0", longint'(wr0), 0);
    check("rel_wr4", longint'(wr4), 0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      read_check($sformatf("rd%0d", i), vecs[i].addr, vecs[i].bc, vecs[i].exp_n, 1'b0);
      check($sformatf("rd%0d_first_data", i), first_data, vecs[i].exp_first);
    end

    // byte-masked single write, read accepted on the very next edge
    wbuf[0] = 32'hAABB_CCDD;
    write_burst(32'h100, 1, 4'b0101, -1, 0, seen);
    read_check("wr100", 32'h100, 5'd1, 1, 1'b0);
    check("wr100_merge", first_data, 32'h00BB_00DD);

    // 4-beat write with a 2-cycle stall carrying a stray read
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
    wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
    write_burst(32'h200, 4, 4'hF, 2, 2, seen);
    check("wrb_no_read", seen, 0);
    read_check("wrb", 32'h200, 5'd5, 5, 1'b0);
    check("wrb_first_data", first_data, 32'h1111_1111);

    // byteenable 0 consumes the beat without changing memory
    wbuf[0] = 32'hFFFF_FFFF;
    write_burst(32'h40, 1, 4'h0, -1, 0, seen);
    read_check("be0", 32'h40, 5'd1, 1, 1'b0);
    check("be0_data", first_data, 32'h10);

    // read and write together: read wins, write dropped
    writedata  = 32'h1234_5678;
    byteenable = 4'hF;
    read_check("rw_both", 32'h300, 5'd1, 1, 1'b1);
    check("rw_both_data", first_data, 32'hC0);
    read_check("rw_after", 32'h300, 5'd1, 1, 1'b0);
    check("rw_after_data", first_data, 32'hC0);

    // reset after the 5th beat of a 16-beat read
    address    = 32'h40;
    burstcount = 5'd16;
    read       = 1'b1;
    @(negedge clk);
    read = 1'b0;
    nb   = 0;
    for (int s = 0; s < 20; s++) begin
      if (rdv0) nb++;
      if (nb == 5) break;
      @(negedge clk);
    end
    check("rstmid_reach5", nb, 5);
    reset = 1'b1;
    #1;
    check("rstmid_rdv0", longint'(rdv0), 0);
    check("rstmid_rdv4", longint'(rdv4), 0);
    check("rstmid_rd0", longint'(rd0), 0);
    check("rstmid_wr0", longint'(wr0), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstmid_rel_wr0", longint'(wr0), 0);
    check("rstmid_rel_wr4", longint'(wr4), 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdv0 || rdv4) extra++;
    end
    check("rstmid_no_beats", extra, 0);
    read_check("rst_after", 32'hFF8, 5'd4, 4, 1'b0);
    check("rst_after_data", first_data, 32'h3FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
